// File: rtl/tl_channel_buffer_pkg.sv
// Shared constants and sizing helpers for the TileLink per-channel buffer.
package tl_channel_buffer_pkg;
    localparam int OpcodeWidth = 3;
    localparam int ParamWidth  = 3;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_GET         = 3'd4
    } tl_a_op_e;

    // Occupancy counter width; a depth-0 channel still exports one (tied-off) bit.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/tl_channel.sv
// TileLink five-channel bundle; "device" modport faces a host, "host" modport faces a device.
interface tl_channel #(
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1,
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3
) ();
    import tl_channel_buffer_pkg::*;
    localparam int MaskWidth = DataWidth / 8;

    logic                   a_valid, a_ready, a_corrupt;
    logic [OpcodeWidth-1:0] a_opcode;
    logic [ParamWidth-1:0]  a_param;
    logic [SizeWidth-1:0]   a_size;
    logic [SourceWidth-1:0] a_source;
    logic [AddrWidth-1:0]   a_address;
    logic [MaskWidth-1:0]   a_mask;
    logic [DataWidth-1:0]   a_data;

    logic                   b_valid, b_ready, b_corrupt;
    logic [OpcodeWidth-1:0] b_opcode;
    logic [ParamWidth-1:0]  b_param;
    logic [SizeWidth-1:0]   b_size;
    logic [SourceWidth-1:0] b_source;
    logic [AddrWidth-1:0]   b_address;
    logic [MaskWidth-1:0]   b_mask;
    logic [DataWidth-1:0]   b_data;

    logic                   c_valid, c_ready, c_corrupt;
    logic [OpcodeWidth-1:0] c_opcode;
    logic [ParamWidth-1:0]  c_param;
    logic [SizeWidth-1:0]   c_size;
    logic [SourceWidth-1:0] c_source;
    logic [AddrWidth-1:0]   c_address;
    logic [DataWidth-1:0]   c_data;

    logic                   d_valid, d_ready, d_denied, d_corrupt;
    logic [OpcodeWidth-1:0] d_opcode;
    logic [ParamWidth-1:0]  d_param;
    logic [SizeWidth-1:0]   d_size;
    logic [SourceWidth-1:0] d_source;
    logic [SinkWidth-1:0]   d_sink;
    logic [DataWidth-1:0]   d_data;

    logic                   e_valid, e_ready;
    logic [SinkWidth-1:0]   e_sink;

    modport device (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
        input  b_ready,
        input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
        output c_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready,
        input  e_valid, e_sink,
        output e_ready
    );

    modport host (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
        output b_ready,
        output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
        input  c_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready,
        output e_valid, e_sink,
        input  e_ready
    );
endinterface

// File: rtl/tl_fifo.sv
// Single-channel elastic buffer: passthrough (Depth 0), registered FIFO, or fall-through FIFO.
module tl_fifo
    import tl_channel_buffer_pkg::*;
#(
    parameter int Width       = 8,
    parameter int Depth       = 2,
    parameter int FallThrough = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [Width-1:0]              enq_data,
    output logic                          deq_valid,
    input  logic                          deq_ready,
    output logic [Width-1:0]              deq_data,
    output logic [count_width(Depth)-1:0] count_o
);
    localparam int CW = count_width(Depth);

    if (FallThrough != 0 && Depth == 0) begin : g_bad_cfg
        $fatal(1, "tl_fifo: FallThrough requires Depth >= 1");
    end

    if (Depth == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign deq_valid = enq_valid;
        assign enq_ready = deq_ready;
        assign deq_data  = enq_data;
        assign count_o   = '0;
    end else begin : g_buf
        localparam int PW = ptr_width(Depth);
        localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);
        localparam logic [CW-1:0] Full    = CW'(Depth);

        logic [Width-1:0] mem [Depth];
        logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
        logic [CW-1:0]    count_reg, count_next;
        logic             ready_reg;
        logic             empty, bypass, wr_en, rd_en;

        // ready_reg is cleared by reset and only rises one cycle later, which also
        // keeps the fall-through path shut for the cycle following reset.
        assign empty     = (count_reg == '0);
        assign bypass    = (FallThrough != 0) && empty;
        assign enq_ready = ready_reg & ~rst_i;
        assign deq_valid = ~rst_i & (empty ? (bypass & enq_valid & ready_reg) : 1'b1);
        assign deq_data  = bypass ? enq_data : mem[rd_ptr_reg];
        assign rd_en     = deq_valid & deq_ready & ~empty;
        assign wr_en     = enq_valid & enq_ready & ~(bypass & deq_ready);
        assign count_o   = rst_i ? '0 : count_reg;

        always_comb begin
            count_next = count_reg;
            if (wr_en && !rd_en) begin
                count_next = count_reg + CW'(1);
            end else if (rd_en && !wr_en) begin
                count_next = count_reg - CW'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
                ready_reg  <= 1'b0;
            end else begin
                count_reg <= count_next;
                ready_reg <= (count_next != Full);
                if (wr_en) begin
                    wr_ptr_reg <= (wr_ptr_reg == LastPtr) ? '0 : wr_ptr_reg + PW'(1);
                end
                if (rd_en) begin
                    rd_ptr_reg <= (rd_ptr_reg == LastPtr) ? '0 : rd_ptr_reg + PW'(1);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (wr_en) begin
                mem[wr_ptr_reg] <= enq_data;
            end
        end
    end
endmodule

// File: rtl/tl_channel_buffer.sv
// TileLink link buffer: one tl_fifo per channel, A/C/E host->device and B/D device->host.
module tl_channel_buffer
    import tl_channel_buffer_pkg::*;
#(
    parameter int SourceWidth  = 1,
    parameter int SinkWidth    = 1,
    parameter int AddrWidth    = 56,
    parameter int DataWidth    = 64,
    parameter int SizeWidth    = 3,
    parameter int ADepth       = 2,
    parameter int BDepth       = 2,
    parameter int CDepth       = 2,
    parameter int DDepth       = 2,
    parameter int EDepth       = 2,
    parameter int AFallThrough = 0,
    parameter int BFallThrough = 0,
    parameter int CFallThrough = 0,
    parameter int DFallThrough = 0,
    parameter int EFallThrough = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    tl_channel.device                      host,
    tl_channel.host                        device,
    output logic [count_width(ADepth)-1:0] a_count_o,
    output logic [count_width(BDepth)-1:0] b_count_o,
    output logic [count_width(CDepth)-1:0] c_count_o,
    output logic [count_width(DDepth)-1:0] d_count_o,
    output logic [count_width(EDepth)-1:0] e_count_o,
    output logic                           idle_o
);
    localparam int MaskWidth = DataWidth / 8;
    localparam int Head      = OpcodeWidth + ParamWidth + SizeWidth + SourceWidth;
    localparam int AWidth    = Head + AddrWidth + MaskWidth + DataWidth + 1;
    localparam int BWidth    = AWidth;
    localparam int CWidth    = Head + AddrWidth + DataWidth + 1;
    localparam int DWidth    = Head + SinkWidth + 1 + DataWidth + 1;
    localparam int EWidth    = SinkWidth;

    logic [AWidth-1:0] a_in, a_out;
    logic [BWidth-1:0] b_in, b_out;
    logic [CWidth-1:0] c_in, c_out;
    logic [DWidth-1:0] d_in, d_out;
    logic [EWidth-1:0] e_in, e_out;

    // Payload is every field except the handshake, packed MSB-first in bundle order.
    assign a_in = {host.a_opcode, host.a_param, host.a_size, host.a_source,
                   host.a_address, host.a_mask, host.a_data, host.a_corrupt};
    assign {device.a_opcode, device.a_param, device.a_size, device.a_source,
            device.a_address, device.a_mask, device.a_data, device.a_corrupt} = a_out;

    assign b_in = {device.b_opcode, device.b_param, device.b_size, device.b_source,
                   device.b_address, device.b_mask, device.b_data, device.b_corrupt};
    assign {host.b_opcode, host.b_param, host.b_size, host.b_source,
            host.b_address, host.b_mask, host.b_data, host.b_corrupt} = b_out;

    assign c_in = {host.c_opcode, host.c_param, host.c_size, host.c_source,
                   host.c_address, host.c_data, host.c_corrupt};
    assign {device.c_opcode, device.c_param, device.c_size, device.c_source,
            device.c_address, device.c_data, device.c_corrupt} = c_out;

    assign d_in = {device.d_opcode, device.d_param, device.d_size, device.d_source,
                   device.d_sink, device.d_denied, device.d_data, device.d_corrupt};
    assign {host.d_opcode, host.d_param, host.d_size, host.d_source,
            host.d_sink, host.d_denied, host.d_data, host.d_corrupt} = d_out;

    assign e_in = host.e_sink;
    assign device.e_sink = e_out;

    tl_fifo #(.Width(AWidth), .Depth(ADepth), .FallThrough(AFallThrough)) u_a (
        .clk_i(clk_i), .rst_i(rst_i),
        .enq_valid(host.a_valid), .enq_ready(host.a_ready), .enq_data(a_in),
        .deq_valid(device.a_valid), .deq_ready(device.a_ready), .deq_data(a_out),
        .count_o(a_count_o)
    );

    tl_fifo #(.Width(BWidth), .Depth(BDepth), .FallThrough(BFallThrough)) u_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .enq_valid(device.b_valid), .enq_ready(device.b_ready), .enq_data(b_in),
        .deq_valid(host.b_valid), .deq_ready(host.b_ready), .deq_data(b_out),
        .count_o(b_count_o)
    );

    tl_fifo #(.Width(CWidth), .Depth(CDepth), .FallThrough(CFallThrough)) u_c (
        .clk_i(clk_i), .rst_i(rst_i),
        .enq_valid(host.c_valid), .enq_ready(host.c_ready), .enq_data(c_in),
        .deq_valid(device.c_valid), .deq_ready(device.c_ready), .deq_data(c_out),
        .count_o(c_count_o)
    );

    tl_fifo #(.Width(DWidth), .Depth(DDepth), .FallThrough(DFallThrough)) u_d (
        .clk_i(clk_i), .rst_i(rst_i),
        .enq_valid(device.d_valid), .enq_ready(device.d_ready), .enq_data(d_in),
        .deq_valid(host.d_valid), .deq_ready(host.d_ready), .deq_data(d_out),
        .count_o(d_count_o)
    );

    tl_fifo #(.Width(EWidth), .Depth(EDepth), .FallThrough(EFallThrough)) u_e (
        .clk_i(clk_i), .rst_i(rst_i),
        .enq_valid(host.e_valid), .enq_ready(host.e_ready), .enq_data(e_in),
        .deq_valid(device.e_valid), .deq_ready(device.e_ready), .deq_data(e_out),
        .count_o(e_count_o)
    );

    assign idle_o = (a_count_o == '0) && (b_count_o == '0) && (c_count_o == '0)
                 && (d_count_o == '0) && (e_count_o == '0);
endmodule
